mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
// - Byte-serial memory controller sitting directly upstream of the byte-wide main memory.
// - Arbitrates between the instruction-fetch port and the load/store data port.
// - Assembles little-endian 32-bit reads from single-byte memory reads.
// - Serialises byte/half/word stores into single-byte memory writes, one per clock.
// PARAMETERS
// - ADDR_WIDTH  17  width of the memory address bus; upper bits of the 32-bit request address are dropped.
// - LEN         32  request data word width.
// - BYTE_SIZE    8  width of one memory cell.
// PORTS
// - clk             in   1           system clock, all state updates on posedge.
// - rst             in   1           synchronous, active-high reset.
// - inst_req        in   1           instruction fetch request; held high until inst_done.
// - inst_addr       in   LEN         fetch byte address; read size is always 4 bytes.
// - inst_data       out  LEN         assembled instruction; valid while inst_done=1.
// - inst_done       out  1           one-cycle completion pulse for the fetch port.
// - data_req        in   1           load/store request; held high until data_done.
// - data_we         in   1           1 = store, 0 = load.
// - data_size       in   2           00 = byte, 01 = half, 10 = word; 11 is treated as word.
// - data_addr       in   LEN         load/store byte address.
// - data_wdata      in   LEN         store data; the low size bytes are used.
// - data_rdata      out  LEN         load result, zero-extended; valid while data_done=1.
// - data_done       out  1           one-cycle completion pulse for the data port.
// - mem_vis_signal  out  2           memory command: IDLE / READ_INST / READ_DATA / WRITE.
// - mem_vis_addr    out  ADDR_WIDTH  byte address presented to memory.
// - writen_data     out  BYTE_SIZE   byte to store when mem_vis_signal = WRITE.
// - mem_data        in   BYTE_SIZE   combinational read byte from memory.
// BEHAVIOUR
// - Reset values: mem_vis_signal=IDLE, mem_vis_addr=0, writen_data=0, inst_done=0, data_done=0,
//   inst_data=0, data_rdata=0, state=S_IDLE, byte counter=0, last_grant=INST.
// - FSM states: S_IDLE, S_READ, S_WRITE, S_DONE.
// - S_IDLE, one request pending: latch addr, size, we and wdata; that requester is the owner.
//   - Go to S_READ (load or fetch) or S_WRITE (store). Counter=0.
// - S_IDLE, both requests pending: grant the port NOT served last (round-robin via last_grant).
//   - Update last_grant on grant.
// - Byte count N = 1, 2 or 4 from the latched size; fetch is always N=4.
// - S_READ, byte k:
//   - Drive mem_vis_addr = base+k (truncated to ADDR_WIDTH; wraps at 2^ADDR_WIDTH).
//   - Drive mem_vis_signal = READ_INST for the fetch owner, READ_DATA for the data owner.
//   - On posedge, capture mem_data into result bits [8k+7:8k]; k++.
//   - After k = N-1, go to S_DONE.
// - S_WRITE, byte k:
//   - Drive mem_vis_signal = WRITE, mem_vis_addr = base+k, writen_data = wdata[8k+7:8k].
//   - Memory commits the byte on that posedge. After k = N-1, go to S_DONE.
// - S_DONE:
//   - mem_vis_signal = IDLE.
//   - Owner's done = 1 for exactly this cycle with its result register stable.
//   - Next state is S_IDLE. No request is accepted in S_DONE.
// - Latency: N access cycles + 1 done cycle, measured from the first cycle in S_READ/S_WRITE.
//   - One grant cycle in S_IDLE precedes them.
//   - Word load: done in cycle 6 counting from req assertion.
// - Requester must drop req in the cycle after done; if still high in S_IDLE it is a new request.
// - Request inputs are ignored while busy; latched values are used, so input changes mid-transaction have no effect.
// - The non-owner done output is always 0. Result bits above 8N are 0.
// - mem_vis_signal is IDLE in every cycle not in S_READ/S_WRITE, so no spurious memory writes occur.
// - rst mid-transaction: return to S_IDLE next cycle with reset values.
//   - Bytes already written stay in memory; no done pulse is issued.
// - Misaligned addresses are legal; bytes are accessed sequentially with wrap.
// STRUCTURE
// - defines.v holds the shared constants:
//   - `IDLE / `READ_INST / `READ_DATA / `WRITE command encodings.
//   - Size codes `SIZE_B=2'b00, `SIZE_H=2'b01, `SIZE_W=2'b10.
//   - FSM state localparams.
// - Single module. The request arbiter stays inline (about 10 lines); no sub-module is needed.
// TESTING
// - Fetch: mem[0x100..0x103] = 11,22,33,44; inst_req at 0x100 -> 4 READ_INST cycles at addr 100..103,
//   then inst_done with inst_data = 0x44332211.
// - Store half: data_wdata = 0xDEADBEEF, size = 01, addr 0x200 -> WRITE EF@0x200 then BE@0x201;
//   a later byte load of 0x201 returns 0x000000BE.
// - Contention: inst_req and data_req asserted together after reset -> data granted first
//   (last_grant = INST); a second simultaneous pair is granted to inst.
// - Wrap: word load at 0x1FFFE -> addresses 1FFFE, 1FFFF, 00000, 00001.
//   - Bytes assembled low-to-high.
// - Reset mid-store: rst asserted after 2 of 4 WRITE cycles of 0xAABBCCDD at 0x300
//   -> mem[0x300] = DD, mem[0x301] = CC, mem[0x302..0x303] unchanged.
//   - No data_done; mem_vis_signal = IDLE next cycle.
// - Held req: data_req kept high after data_done -> a second identical transaction starts.
//   - The idle gap is exactly one S_IDLE cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, memory command codes, size codes and FSM types for mem_ctrl.
//   ADDR_WIDTH - memory address width, LEN - request word width, BYTE_SIZE - memory cell width.
//   mem_cmd_t  - memory command driven on mem_vis_signal.
//   state_t    - controller FSM states; owner_t - which port owns the transaction.
package mem_ctrl_pkg;

    localparam int ADDR_WIDTH = 17;
    localparam int LEN        = 32;
    localparam int BYTE_SIZE  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        READ_INST = 2'b01,
        READ_DATA = 2'b10,
        WRITE     = 2'b11
    } mem_cmd_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

    // Index of the final byte of a transaction (N-1); fetches are always 4 bytes, size 11 acts as word.
    function automatic logic [1:0] last_idx(input logic is_inst, input logic [1:0] size);
        return is_inst ? 2'd3 : size == SIZE_B ? 2'd0 : size == SIZE_H ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request ports and byte-wide memory bus of mem_ctrl.
//   inst_*         - instruction fetch port (req/addr in, data/done out).
//   data_*         - load/store port (req/we/size/addr/wdata in, rdata/done out).
//   mem_vis_signal - memory command; mem_vis_addr - byte address; writen_data - store byte.
//   mem_data       - combinational read byte returned by memory.
//   slave  - controller view; master - requesters and memory view.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  inst_req;
    logic [LEN-1:0]        inst_addr;
    logic [LEN-1:0]        inst_data;
    logic                  inst_done;
    logic                  data_req;
    logic                  data_we;
    logic [1:0]            data_size;
    logic [LEN-1:0]        data_addr;
    logic [LEN-1:0]        data_wdata;
    logic [LEN-1:0]        data_rdata;
    logic                  data_done;
    mem_cmd_t              mem_vis_signal;
    logic [ADDR_WIDTH-1:0] mem_vis_addr;
    logic [BYTE_SIZE-1:0]  writen_data;
    logic [BYTE_SIZE-1:0]  mem_data;

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_size, data_addr, data_wdata, mem_data,
        output inst_data, inst_done, data_rdata, data_done, mem_vis_signal, mem_vis_addr, writen_data
    );

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_size, data_addr, data_wdata, mem_data,
        input  inst_data, inst_done, data_rdata, data_done, mem_vis_signal, mem_vis_addr, writen_data
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating instruction fetch and load/store ports.
//   clk - system clock; rst - synchronous active-high reset.
//   bus - mem_ctrl_if.slave: request ports in, results/done pulses and memory command bus out.
//   Reads assemble little-endian words one byte per clock; stores emit one byte write per clock.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    state_t                state;
    owner_t                owner;
    owner_t                last_grant;
    logic [1:0]            k;
    logic [1:0]            last;
    logic [LEN-1:0]        wdata;

    logic                  grant_data;
    logic                  is_store;
    logic [1:0]            k_nx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  unused_addr_bits;

    // Data wins when alone, or under contention when the fetch port won the previous contest.
    assign grant_data       = bus.data_req && (!bus.inst_req || last_grant == OWN_INST);
    assign is_store         = grant_data && bus.data_we;
    assign grant_addr       = grant_data ? bus.data_addr[ADDR_WIDTH-1:0] : bus.inst_addr[ADDR_WIDTH-1:0];
    assign k_nx             = k + 2'd1;
    assign unused_addr_bits = &{1'b0, bus.data_addr[LEN-1:ADDR_WIDTH], bus.inst_addr[LEN-1:ADDR_WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            owner              <= OWN_INST;
            last_grant         <= OWN_INST;
            k                  <= '0;
            last               <= '0;
            wdata              <= '0;
            bus.mem_vis_signal <= IDLE;
            bus.mem_vis_addr   <= '0;
            bus.writen_data    <= '0;
            bus.inst_done      <= 1'b0;
            bus.data_done      <= 1'b0;
            bus.inst_data      <= '0;
            bus.data_rdata     <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.inst_req || bus.data_req) begin
                    owner <= grant_data ? OWN_DATA : OWN_INST;
                    // Only contested grants move the round-robin pointer.
                    if (bus.inst_req && bus.data_req)
                        last_grant <= grant_data ? OWN_DATA : OWN_INST;
                    k                  <= '0;
                    last               <= last_idx(!grant_data, bus.data_size);
                    wdata              <= bus.data_wdata;
                    bus.mem_vis_addr   <= grant_addr;
                    bus.mem_vis_signal <= is_store ? WRITE : grant_data ? READ_DATA : READ_INST;
                    bus.writen_data    <= is_store ? bus.data_wdata[BYTE_SIZE-1:0] : '0;
                    // Clearing the owner's result keeps bytes above 8N at zero.
                    if (grant_data)
                        bus.data_rdata <= '0;
                    else
                        bus.inst_data <= '0;
                    state <= is_store ? S_WRITE : S_READ;
                end
                S_READ, S_WRITE: begin
                    if (state == S_READ && owner == OWN_DATA)
                        bus.data_rdata[{k, 3'b000} +: BYTE_SIZE] <= bus.mem_data;
                    if (state == S_READ && owner == OWN_INST)
                        bus.inst_data[{k, 3'b000} +: BYTE_SIZE] <= bus.mem_data;
                    if (k == last) begin
                        state              <= S_DONE;
                        bus.mem_vis_signal <= IDLE;
                        bus.writen_data    <= '0;
                        bus.inst_done      <= owner == OWN_INST;
                        bus.data_done      <= owner == OWN_DATA;
                    end else begin
                        k                <= k_nx;
                        bus.mem_vis_addr <= bus.mem_vis_addr + 1'b1;
                        bus.writen_data  <= state == S_WRITE ? wdata[{k_nx, 3'b000} +: BYTE_SIZE] : '0;
                    end
                end
                S_DONE: begin
                    bus.inst_done <= 1'b0;
                    bus.data_done <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-array memory and reference model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int MSIZE = 1 << ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if bus();
    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem     [0:MSIZE-1];
    logic [7:0] ref_mem [0:MSIZE-1];
    assign bus.mem_data = mem[bus.mem_vis_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit chk; logic [31:0] v; } exp_t;
    typedef struct { logic [1:0] cmd; logic [ADDR_WIDTH-1:0] a; logic [7:0] w; } bus_t;
    exp_t iq[$];
    exp_t dq[$];
    bus_t trace[$];
    bit   order_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r = '0;
        logic [ADDR_WIDTH-1:0] p = a[ADDR_WIDTH-1:0];
        for (int i = 0; i < n; i++) begin
            r[8*i +: 8] = ref_mem[p];
            p = p + 1'b1;
        end
        return r;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_vis_signal != IDLE)
                trace.push_back('{bus.mem_vis_signal, bus.mem_vis_addr, bus.writen_data});
            if (bus.inst_done || bus.data_done)
                check("single_done", {31'b0, bus.inst_done & bus.data_done}, 32'd0);
            if (bus.inst_done) begin
                order_q.push_back(1'b0);
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL inst_unexpected_done: got done=1 expected none at cycle %0d", cyc);
                end else begin
                    e = iq.pop_front();
                    check("inst_data", bus.inst_data, e.v);
                end
            end
            if (bus.data_done) begin
                order_q.push_back(1'b1);
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL data_unexpected_done: got done=1 expected none at cycle %0d", cyc);
                end else begin
                    e = dq.pop_front();
                    if (e.chk) check("data_rdata", bus.data_rdata, e.v);
                end
            end
        end
    endtask

    task automatic mem_proc();
        forever begin
            @(posedge clk);
            if (bus.mem_vis_signal == WRITE) mem[bus.mem_vis_addr] <= bus.writen_data;
        end
    endtask

    task automatic wait_done(input bit inst, output int c);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (inst ? bus.inst_done : bus.data_done) begin
                c = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done expected one within 100 cycles", inst ? "inst" : "data");
        c = cyc;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_inst(input logic [31:0] a, output int lat);
        int c0, c;
        iq.push_back('{1'b1, ref_read(a, 4)});
        bus.inst_addr = a;
        bus.inst_req  = 1'b1;
        c0 = cyc;
        wait_done(1'b1, c);
        lat = c - c0;
        @(posedge clk);
        #1;
        bus.inst_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold, output int lat);
        int c0, c;
        int n = nbytes(sz);
        logic [ADDR_WIDTH-1:0] p = a[ADDR_WIDTH-1:0];
        dq.push_back('{!we, we ? 32'd0 : ref_read(a, n)});
        if (we)
            for (int i = 0; i < n; i++) begin
                ref_mem[p] = wd[8*i +: 8];
                p = p + 1'b1;
            end
        bus.data_we    = we;
        bus.data_size  = sz;
        bus.data_addr  = a;
        bus.data_wdata = wd;
        bus.data_req   = 1'b1;
        c0 = cyc;
        wait_done(1'b0, c);
        lat = c - c0;
        if (!hold) begin
            @(posedge clk);
            #1;
            bus.data_req = 1'b0;
        end
    endtask

    task automatic check_trace(input string name, input int idx, input logic [1:0] cmd,
                               input logic [ADDR_WIDTH-1:0] a, input logic [7:0] w, input bit chk_w);
        if (idx >= trace.size()) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d bus cycles expected more than %0d", name, trace.size(), idx);
        end else begin
            check({name, "_cmd"}, 32'(trace[idx].cmd), 32'(cmd));
            check({name, "_addr"}, 32'(trace[idx].a), 32'(a));
            if (chk_w) check({name, "_wdata"}, 32'(trace[idx].w), 32'(w));
        end
    endtask

    initial begin
        int lat, l2, c1, c2, diff;
        logic [7:0] old302, old303;
        for (int i = 0; i < MSIZE; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[32'h100 + i] = 8'(8'h11 * (i + 1));
        end
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_size = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
        fork
            monitor();
            mem_proc();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_signal", 32'(bus.mem_vis_signal), 32'(IDLE));
        check("rst_addr", 32'(bus.mem_vis_addr), 32'd0);
        check("rst_wdata", 32'(bus.writen_data), 32'd0);
        check("rst_done", {30'b0, bus.inst_done, bus.data_done}, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        check("rst_data_rdata", bus.data_rdata, 32'd0);
        rst = 1'b0;

        // Contention: first pair goes to data, second pair to fetch.
        order_q.delete();
        fork
            do_inst(32'h0000_8000, lat);
            do_data(1'b0, 2'b10, 32'h0000_8100, 32'd0, 1'b0, l2);
        join
        fork
            do_inst(32'h0000_8200, lat);
            do_data(1'b0, 2'b01, 32'h0000_8300, 32'd0, 1'b0, l2);
        join
        check("arb_count", order_q.size(), 32'd4);
        if (order_q.size() == 4) begin
            check("arb_first_pair_0", 32'(order_q[0]), 32'd1);
            check("arb_first_pair_1", 32'(order_q[1]), 32'd0);
            check("arb_second_pair_0", 32'(order_q[2]), 32'd0);
            check("arb_second_pair_1", 32'(order_q[3]), 32'd1);
        end

        trace.delete();
        do_inst(32'h0000_0100, lat);
        check("fetch_latency", lat, 32'd5);
        check("fetch_bus_len", trace.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check_trace("fetch_bus", i, READ_INST, ADDR_WIDTH'(32'h100 + i), 8'h0, 1'b0);

        trace.delete();
        do_data(1'b1, 2'b01, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, lat);
        check("store_half_bus_len", trace.size(), 32'd2);
        check_trace("store_half_b0", 0, WRITE, 17'h00200, 8'hEF, 1'b1);
        check_trace("store_half_b1", 1, WRITE, 17'h00201, 8'hBE, 1'b1);
        do_data(1'b0, 2'b00, 32'h0000_0201, 32'd0, 1'b0, lat);
        check("byte_load_latency", lat, 32'd2);

        trace.delete();
        do_data(1'b0, 2'b10, 32'hABC1_FFFE, 32'd0, 1'b0, lat);
        check("word_load_latency", lat, 32'd5);
        check("wrap_bus_len", trace.size(), 32'd4);
        check_trace("wrap_b0", 0, READ_DATA, 17'h1FFFE, 8'h0, 1'b0);
        check_trace("wrap_b1", 1, READ_DATA, 17'h1FFFF, 8'h0, 1'b0);
        check_trace("wrap_b2", 2, READ_DATA, 17'h00000, 8'h0, 1'b0);
        check_trace("wrap_b3", 3, READ_DATA, 17'h00001, 8'h0, 1'b0);

        // Reset during the second of four store cycles.
        old302 = ref_mem[17'h302];
        old303 = ref_mem[17'h303];
        ref_mem[17'h300] = 8'hDD;
        ref_mem[17'h301] = 8'hCC;
        bus.data_we = 1'b1; bus.data_size = 2'b10;
        bus.data_addr = 32'h0000_0300; bus.data_wdata = 32'hAABB_CCDD;
        bus.data_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.data_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_signal", 32'(bus.mem_vis_signal), 32'(IDLE));
        check("rst_mid_done", 32'(bus.data_done), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_300", 32'(mem[17'h300]), 32'hDD);
        check("rst_mid_301", 32'(mem[17'h301]), 32'hCC);
        check("rst_mid_302", 32'(mem[17'h302]), 32'(old302));
        check("rst_mid_303", 32'(mem[17'h303]), 32'(old303));

        // Held request repeats after exactly one idle cycle.
        do_data(1'b0, 2'b00, 32'h0000_8010, 32'd0, 1'b1, lat);
        c1 = cyc;
        dq.push_back('{1'b1, ref_read(32'h0000_8010, 1)});
        wait_done(1'b0, c2);
        check("held_req_gap", c2 - c1, 32'd3);
        @(posedge clk); #1;
        bus.data_req = 1'b0;

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a = $urandom;
                    a[16:14] = 3'b010;
                    do_inst(a, lat);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    logic [31:0] a = $urandom;
                    logic we = 1'($urandom);
                    if (we) a[16] = 1'b1;
                    do_data(we, 2'($urandom_range(0, 3)), a, $urandom, 1'b0, l2);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("inst_queue_left", iq.size(), 32'd0);
        check("data_queue_left", dq.size(), 32'd0);
        diff = 0;
        for (int i = 0; i < MSIZE; i++)
            if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image_diffs", diff, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
